// File: rtl/unidade_acesso_memoria.sv
// Load/store sequencer in front of the data memory: computes base+offset,
// drives EscMem/LerMem for single-byte stores and 1..4-beat load bursts.
module unidade_acesso_memoria #(
    parameter int unsigned LARGURA_DADO = 8,
    parameter int unsigned LARGURA_END  = 8,
    parameter int unsigned BITS_QUANT   = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Requisicao,
    input  logic                    Escrita,
    input  logic [LARGURA_END-1:0]  Base,
    input  logic [LARGURA_END-1:0]  Deslocamento,
    input  logic [BITS_QUANT-1:0]   Quant,
    input  logic [LARGURA_DADO-1:0] DadoEntrada,
    output logic                    Ocupado,
    output logic [LARGURA_DADO-1:0] DadoSaida,
    output logic                    DadoValido,
    output logic                    Fim,
    output logic [LARGURA_END-1:0]  Endereco,
    output logic [LARGURA_DADO-1:0] DadoEscrito,
    output logic                    EscMem,
    output logic                    LerMem,
    input  logic [LARGURA_DADO-1:0] DadoLido
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCREVER = 2'd1,
        LER      = 2'd2
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [BITS_QUANT-1:0]   cont_q, cont_d;
    logic [LARGURA_END-1:0]  endereco_q, endereco_d;
    logic [LARGURA_DADO-1:0] dado_escrito_q, dado_escrito_d;
    logic [LARGURA_DADO-1:0] dado_saida_q, dado_saida_d;
    logic                    dado_valido_q, dado_valido_d;
    logic                    fim_q, fim_d;
    logic                    esc_mem_q, esc_mem_d;
    logic                    ler_mem_q, ler_mem_d;
    logic [LARGURA_END-1:0]  end_efetivo;

    // Carry out of the address add is discarded (wraps modulo 2^LARGURA_END).
    assign end_efetivo = LARGURA_END'(Base + Deslocamento);

    // State and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_q       <= OCIOSO;
            cont_q         <= '0;
            endereco_q     <= '0;
            dado_escrito_q <= '0;
            dado_saida_q   <= '0;
            dado_valido_q  <= 1'b0;
            fim_q          <= 1'b0;
            esc_mem_q      <= 1'b0;
            ler_mem_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cont_q         <= cont_d;
            endereco_q     <= endereco_d;
            dado_escrito_q <= dado_escrito_d;
            dado_saida_q   <= dado_saida_d;
            dado_valido_q  <= dado_valido_d;
            fim_q          <= fim_d;
            esc_mem_q      <= esc_mem_d;
            ler_mem_q      <= ler_mem_d;
        end
    end

    // Next-state and next-output logic; strobes default low each cycle.
    always_comb begin
        estado_d       = estado_q;
        cont_d         = cont_q;
        endereco_d     = endereco_q;
        dado_escrito_d = dado_escrito_q;
        dado_saida_d   = dado_saida_q;
        dado_valido_d  = 1'b0;
        fim_d          = 1'b0;
        esc_mem_d      = esc_mem_q;
        ler_mem_d      = ler_mem_q;

        unique case (estado_q)
            OCIOSO: begin
                if (Requisicao) begin
                    endereco_d = end_efetivo;
                    if (Escrita) begin
                        estado_d       = ESCREVER;
                        esc_mem_d      = 1'b1;
                        ler_mem_d      = 1'b0;
                        dado_escrito_d = DadoEntrada;
                    end else begin
                        estado_d  = LER;
                        ler_mem_d = 1'b1;
                        esc_mem_d = 1'b0;
                        cont_d    = Quant;
                    end
                end
            end
            ESCREVER: begin
                estado_d  = OCIOSO;
                esc_mem_d = 1'b0;
                fim_d     = 1'b1;
            end
            LER: begin
                // DadoLido was fetched on the preceding negedge for endereco_q.
                dado_saida_d  = DadoLido;
                dado_valido_d = 1'b1;
                if (cont_q == '0) begin
                    estado_d  = OCIOSO;
                    ler_mem_d = 1'b0;
                    fim_d     = 1'b1;
                end else begin
                    cont_d     = cont_q - 1'b1;
                    endereco_d = endereco_q + 1'b1;
                end
            end
            default: begin
                estado_d  = OCIOSO;
                esc_mem_d = 1'b0;
                ler_mem_d = 1'b0;
            end
        endcase
    end

    assign Ocupado     = (estado_q != OCIOSO);
    assign DadoSaida   = dado_saida_q;
    assign DadoValido  = dado_valido_q;
    assign Fim         = fim_q;
    assign Endereco    = endereco_q;
    assign DadoEscrito = dado_escrito_q;
    assign EscMem      = esc_mem_q;
    assign LerMem      = ler_mem_q;

endmodule
